// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared widths, FSM encoding and debug entry type for the regfile write arbiter
package regfile_write_arbiter_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  typedef enum logic {CPU_PRI, FORCE_DBG} state_e;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } dbg_entry_t;
endpackage

// File: rtl/regwb_fifo.sv
// regwb_fifo: circular debug-write buffer with occupancy count; the head is registered storage, so no fall-through
module regwb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  dbg_entry_t wdata,
  output dbg_entry_t rdata,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  dbg_entry_t mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign rdata = mem_q[rp_q];
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      if (push != pop) cnt_q <= push ? cnt_q + CW'(1) : cnt_q - CW'(1);
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between core writeback and buffered SPI debug writes.
// Optional build macro REGWB_X0_FILTER_EN drops writes to x0 from both sources.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_waddr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  input  logic          dbg_valid,
  output logic          dbg_ready,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_data,
  output logic          dbg_pending,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic push, pop, full, empty, cpu_go, cpu_ok, dbg_ok;
  dbg_entry_t head;
`ifdef REGWB_X0_FILTER_EN
  assign cpu_ok = |cpu_waddr;
  assign dbg_ok = |dbg_addr;
`else
  assign cpu_ok = 1'b1;
  assign dbg_ok = 1'b1;
`endif
  assign dbg_ready = !full;
  assign push = dbg_valid && !full && dbg_ok;
  assign dbg_pending = !empty;
  assign cpu_stall = state_q == FORCE_DBG;
  regwb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata('{addr: dbg_addr, data: dbg_data}),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= CPU_PRI;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    cnt_d = (pop || empty) ? '0 : cnt_q + 8'd1;
    state_d = (state_q == CPU_PRI && cnt_d == 8'(STARVE_LIMIT)) ? FORCE_DBG : CPU_PRI;
  end
  // The stall cycle blanks the core, so the head always drains there.
  always_comb begin
    cpu_go = state_q == CPU_PRI && cpu_we && cpu_ok;
    pop = !empty && !cpu_go;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= cpu_go || pop;
      if (cpu_go || pop) begin
        rf_waddr <= cpu_go ? cpu_waddr : head.addr;
        rf_wdata <= cpu_go ? cpu_wdata : head.data;
      end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors with hand-computed expectations for regfile_write_arbiter
module tb_regfile_write_arbiter;
  logic clk, rst, cpu_we, cpu_stall, dbg_valid, dbg_ready, dbg_pending, rf_we;
  logic [4:0] cpu_waddr, dbg_addr, rf_waddr;
  logic [31:0] cpu_wdata, dbg_data, rf_wdata;
  int checks, failures;
  regfile_write_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .dbg_pending(dbg_pending), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic seen;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
    dbg_valid = 1'b0; dbg_addr = '0; dbg_data = '0;
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_pending", dbg_pending, 0);
    chk("rst_ready", dbg_ready, 1);
    // Core write, latency 1, one-cycle pulse
    cpu_we = 1'b1; cpu_waddr = 5'd5; cpu_wdata = 32'hDEADBEEF;
    step();
    cpu_we = 1'b0;
    chk("cpu_we", rf_we, 1);
    chk("cpu_addr", rf_waddr, 5);
    chk("cpu_data", rf_wdata, 32'hDEADBEEF);
    step();
    chk("cpu_pulse", rf_we, 0);
    // Debug write on an idle port
    dbg_valid = 1'b1; dbg_addr = 5'd7; dbg_data = 32'h12345678;
    step();
    dbg_valid = 1'b0;
    chk("dbg_accept_pending", dbg_pending, 1);
    chk("dbg_no_fallthru", rf_we, 0);
    step();
    chk("dbg_we", rf_we, 1);
    chk("dbg_addr", rf_waddr, 7);
    chk("dbg_data", rf_wdata, 32'h12345678);
    chk("dbg_pending_fall", dbg_pending, 0);
    // Starvation: core writes every cycle while four debug entries queue
    cpu_we = 1'b1; cpu_waddr = 5'd1; cpu_wdata = 32'h11;
    for (int k = 0; k < 4; k++) begin
      dbg_valid = 1'b1; dbg_addr = 5'(10 + k); dbg_data = 32'h100 + k;
      step();
    end
    dbg_valid = 1'b0;
    chk("full_ready", dbg_ready, 0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!cpu_stall && n < 20) begin
        step();
        n++;
      end
      chk("starve_wait", n, k == 0 ? 5 : 8);
      chk("blocked_core_addr", rf_waddr, 1);
      step();
      chk("force_we", rf_we, 1);
      chk("force_addr", rf_waddr, 10 + k);
      chk("force_data", rf_wdata, 32'h100 + k);
      chk("stall_one_cycle", cpu_stall, 0);
    end
    chk("drained_pending", dbg_pending, 0);
    chk("drained_ready", dbg_ready, 1);
    cpu_we = 1'b0;
    step();
    // Same-address ordering: core then debug, debug wins
    dbg_valid = 1'b1; dbg_addr = 5'd3; dbg_data = 32'hB;
    step();
    dbg_valid = 1'b0;
    cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'hA;
    step();
    cpu_we = 1'b0;
    chk("order_first", rf_wdata, 32'hA);
    step();
    chk("order_second_addr", rf_waddr, 3);
    chk("order_last_wins", rf_wdata, 32'hB);
    step();
    // Reset with three queued entries
    cpu_we = 1'b1; cpu_waddr = 5'd2; cpu_wdata = 32'h22;
    for (int k = 0; k < 3; k++) begin
      dbg_valid = 1'b1; dbg_addr = 5'(20 + k); dbg_data = 32'h200 + k;
      step();
    end
    dbg_valid = 1'b0;
    chk("pre_rst_pending", dbg_pending, 1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_pending", dbg_pending, 0);
    chk("async_rst_we", rf_we, 0);
    cpu_we = 1'b0;
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      seen |= rf_we;
    end
    chk("rst_discards_queue", seen, 0);
    // Writes to x0
    cpu_we = 1'b1; cpu_waddr = 5'd0; cpu_wdata = 32'hFFFFFFFF;
    step();
    cpu_we = 1'b0;
`ifdef REGWB_X0_FILTER_EN
    chk("x0_filtered_we", rf_we, 0);
`else
    chk("x0_pass_we", rf_we, 1);
    chk("x0_pass_addr", rf_waddr, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
